// File: rtl/serdes_prbs_pkg.sv
// Shared types and helpers for the SERDES PRBS link tester: lane states,
// PRBS7 taps and seed, training pattern, priming and slip limits.
package serdes_prbs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRAIN = 2'd1,
      ST_PRBS  = 2'd2,
      ST_FAIL  = 2'd3
   } lane_state_e;

   // x^7 + x^6 + 1: next bit = bit 7 ago XOR bit 6 ago
   localparam int         PRBS_TAP_HI = 6;
   localparam int         PRBS_TAP_LO = 5;
   localparam logic [6:0] PRBS_SEED   = 7'h7F;

   function automatic logic [7:0] train_pat(input int width);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < width / 2; i++) p[i] = 1'b1;
      return p;
   endfunction

   function automatic int prime_words(input int width);
      return (7 + width - 1) / width;
   endfunction

   function automatic int max_slips(input int width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/serdes_prbs_lane.sv
// One tester lane: train/bitslip alignment FSM, PRBS7 generator,
// self-synchronising PRBS7 checker and saturating error counter.
module serdes_prbs_lane
   import serdes_prbs_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int LOCK_COUNT    = 16,
   parameter int SLIP_WAIT     = 3,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     clear,
   input  logic                     inject,
   input  logic [DATA_WIDTH-1:0]    rx_data,
   output logic [DATA_WIDTH-1:0]    tx_data,
   output logic                     bitslip,
   output logic                     locked,
   output logic                     fail,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   localparam logic [7:0]               PAT_FULL  = train_pat(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0]    TRAIN_PAT = PAT_FULL[DATA_WIDTH-1:0];
   localparam int                       PRIME     = prime_words(DATA_WIDTH);
   localparam int                       SLIPS     = max_slips(DATA_WIDTH);
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE   = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

   lane_state_e             state_q;
   logic [DATA_WIDTH-1:0]   tx_q;
   logic                    bitslip_q, locked_q, fail_q, started_q;
   logic [ERR_CNT_WIDTH-1:0] err_q;
   logic [6:0]              gen_q, gen_d, hist_q, hist_d;
   logic [15:0]             match_q;
   logic [7:0]              wait_q;
   logic [4:0]              slip_q;
   logic [3:0]              prime_q;
   logic [DATA_WIDTH-1:0]   gen_word, inj_mask;
   logic                    word_err, count_en;

   always_comb begin
      gen_d    = gen_q;
      hist_d   = hist_q;
      gen_word = '0;
      word_err = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         gen_word[i] = gen_d[PRBS_TAP_HI] ^ gen_d[PRBS_TAP_LO];
         gen_d       = {gen_d[5:0], gen_word[i]};
         word_err    = word_err | (hist_d[PRBS_TAP_HI] ^ hist_d[PRBS_TAP_LO] ^ rx_data[i]);
         hist_d      = {hist_d[5:0], rx_data[i]};
      end
      inj_mask    = '0;
      inj_mask[0] = inject;
      count_en    = enable && (state_q == ST_PRBS) && started_q && (prime_q == 4'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         tx_q      <= '0;
         bitslip_q <= 1'b0;
         locked_q  <= 1'b0;
         fail_q    <= 1'b0;
         err_q     <= '0;
         gen_q     <= PRBS_SEED;
         hist_q    <= '0;
         match_q   <= '0;
         wait_q    <= '0;
         slip_q    <= '0;
         prime_q   <= '0;
         started_q <= 1'b0;
      end else begin
         bitslip_q <= 1'b0;
         hist_q    <= hist_d;
         if (clear)
            err_q <= '0;
         else if (count_en && word_err && (err_q != '1))
            err_q <= err_q + CNT_ONE;

         if (!enable) begin
            state_q  <= ST_IDLE;
            tx_q     <= '0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  // Entry wait flushes stale words still in the loopback path.
                  state_q <= ST_TRAIN;
                  tx_q    <= TRAIN_PAT;
                  wait_q  <= 8'(SLIP_WAIT);
                  match_q <= '0;
                  slip_q  <= '0;
               end
               ST_TRAIN: begin
                  if (wait_q != 8'd0) begin
                     wait_q <= wait_q - 8'd1;
                  end else if (rx_data == TRAIN_PAT) begin
                     if (match_q == 16'(LOCK_COUNT - 1)) begin
                        state_q   <= ST_PRBS;
                        locked_q  <= 1'b1;
                        gen_q     <= PRBS_SEED;
                        started_q <= 1'b0;
                     end else begin
                        match_q <= match_q + 16'd1;
                     end
                  end else begin
                     match_q <= '0;
                     if (slip_q == 5'(SLIPS)) begin
                        state_q <= ST_FAIL;
                        fail_q  <= 1'b1;
                        tx_q    <= '0;
                     end else begin
                        bitslip_q <= 1'b1;
                        slip_q    <= slip_q + 5'd1;
                        wait_q    <= 8'(SLIP_WAIT);
                     end
                  end
               end
               ST_PRBS: begin
                  tx_q  <= gen_word ^ inj_mask;
                  gen_q <= gen_d;
                  // Priming starts with the first non-training word, so the
                  // loopback latency never shows up as errors.
                  if (!started_q) begin
                     if (rx_data != TRAIN_PAT) begin
                        started_q <= 1'b1;
                        prime_q   <= 4'(PRIME - 1);
                     end
                  end else if (prime_q != 4'd0) begin
                     prime_q <= prime_q - 4'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign tx_data   = tx_q;
   assign bitslip   = bitslip_q;
   assign locked    = locked_q;
   assign fail      = fail_q;
   assign err_count = err_q;

endmodule

// File: rtl/serdes_prbs_tester.sv
// Multi-lane SERDES PRBS7 link tester top: lane array plus error_any.
// Optional SERDES_PRBS_ERR_INJECT_EN adds per-lane single-bit error injection.
module serdes_prbs_tester
   import serdes_prbs_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int CHANNELS      = 4,
   parameter int LOCK_COUNT    = 16,
   parameter int SLIP_WAIT     = 3,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              enable,
   input  logic                              clear,
   output logic [CHANNELS*DATA_WIDTH-1:0]    tx_data,
   input  logic [CHANNELS*DATA_WIDTH-1:0]    rx_data,
   output logic [CHANNELS-1:0]               bitslip,
   output logic [CHANNELS-1:0]               locked,
   output logic [CHANNELS-1:0]               fail,
   output logic [CHANNELS*ERR_CNT_WIDTH-1:0] err_count,
   output logic                              error_any
`ifdef SERDES_PRBS_ERR_INJECT_EN
   ,
   input  logic [CHANNELS-1:0]               inject
`endif
);

   logic [CHANNELS-1:0] inject_w;
   logic [CHANNELS-1:0] lane_nz;
   logic                error_any_q;

`ifdef SERDES_PRBS_ERR_INJECT_EN
   assign inject_w = inject;
`else
   assign inject_w = '0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
         serdes_prbs_lane #(
            .DATA_WIDTH   (DATA_WIDTH),
            .LOCK_COUNT   (LOCK_COUNT),
            .SLIP_WAIT    (SLIP_WAIT),
            .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
         ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .enable   (enable),
            .clear    (clear),
            .inject   (inject_w[gi]),
            .rx_data  (rx_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .tx_data  (tx_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .bitslip  (bitslip[gi]),
            .locked   (locked[gi]),
            .fail     (fail[gi]),
            .err_count(err_count[gi*ERR_CNT_WIDTH +: ERR_CNT_WIDTH])
         );
         assign lane_nz[gi] = |err_count[gi*ERR_CNT_WIDTH +: ERR_CNT_WIDTH];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) error_any_q <= 1'b0;
      else        error_any_q <= |lane_nz;
   end

   assign error_any = error_any_q;

endmodule

// File: tb/tb_serdes_prbs_tester.sv
// Self-checking bench: modelled loopback with per-lane rotation/stuck/invert,
// PRBS7 reference stream, alignment, fail, saturation, clear and reset checks.
module tb_serdes_prbs_tester;

   localparam int DW = 8, CH = 4, LC = 16, SW = 3, ECW = 10;
   localparam logic [DW-1:0] PAT = 8'h0F;

   logic               clk = 1'b0;
   logic               rst_n, enable, clear;
   logic [CH*DW-1:0]   tx_data, rx_data;
   logic [CH-1:0]      bitslip, locked, fail;
   logic [CH*ECW-1:0]  err_count;
   logic               error_any;
`ifdef SERDES_PRBS_ERR_INJECT_EN
   logic [CH-1:0]      inject;
`endif

   int total = 0, bad = 0;
   int cyc = 0, gap_bad = 0;
   int last_slip[CH] = '{default: -100};
   int slip_total[CH] = '{default: 0};
   int rot_base[CH] = '{default: 0};
   int mode[CH] = '{default: 0};   // 0 loopback, 1 stuck at zero, 2 inverted
   logic [DW-1:0] d1[CH], d2[CH];
   logic [DW-1:0] cap[$];
   logic          cap_on = 1'b0;
   logic          model_bits[$];

   serdes_prbs_tester #(
      .DATA_WIDTH(DW), .CHANNELS(CH), .LOCK_COUNT(LC), .SLIP_WAIT(SW), .ERR_CNT_WIDTH(ECW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
      .tx_data(tx_data), .rx_data(rx_data), .bitslip(bitslip), .locked(locked),
      .fail(fail), .err_count(err_count), .error_any(error_any)
`ifdef SERDES_PRBS_ERR_INJECT_EN
      , .inject(inject)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] link_word(input logic [DW-1:0] v, input int r, input int m);
      logic [DW-1:0] w = v;
      for (int i = 0; i < r; i++) w = {w[DW-2:0], w[DW-1]};
      if (m == 1) w = '0;
      else if (m == 2) w = ~w;
      return w;
   endfunction

   function automatic logic [DW-1:0] model_word(input int k);
      logic [DW-1:0] w = '0;
      for (int j = 0; j < DW; j++) w[j] = model_bits[7 + k*DW + j];
      return w;
   endfunction

   // Two-cycle loopback; each bitslip rotates the lane back by one bit.
   always_comb begin
      rx_data = '0;
      for (int l = 0; l < CH; l++)
         rx_data[l*DW +: DW] = link_word(d2[l], ((rot_base[l] - slip_total[l]) % DW + DW) % DW, mode[l]);
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int l = 0; l < CH; l++) begin
         d1[l] <= tx_data[l*DW +: DW];
         d2[l] <= d1[l];
         if (bitslip[l]) begin
            slip_total[l] <= slip_total[l] + 1;
            if (cyc - last_slip[l] < SW + 1) gap_bad = gap_bad + 1;
            last_slip[l] = cyc;
         end
      end
   end

   always @(negedge clk)
      if (cap_on && locked[3] && cap.size() < 48) cap.push_back(tx_data[3*DW +: DW]);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t3, r2, errs, start, held, wpi, prev_w, found;
      int s0[CH];
      logic exp_any;
      int pos[3] = '{0, 6, 7};

      for (int n = 0; n < 7; n++) model_bits.push_back(1'b1);
      for (int n = 7; n < 7 + 40*DW; n++) model_bits.push_back(model_bits[n-7] ^ model_bits[n-6]);

      rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
`ifdef SERDES_PRBS_ERR_INJECT_EN
      inject = '0;
`endif
      repeat (3) @(negedge clk);
      check("rst_tx", tx_data, 0);
      check("rst_bitslip", bitslip, 0);
      check("rst_locked", locked, 0);
      check("rst_fail", fail, 0);
      check("rst_err", err_count, 0);
      check("rst_any", error_any, 0);

      // Lane 0 stuck at 0, lane 1 rotated 3, lane 2 random rotation, lane 3 ideal.
      r2 = $urandom_range(0, DW-1);
      rot_base[1] = 3; rot_base[2] = r2; mode[0] = 1;
      for (int l = 0; l < CH; l++) s0[l] = slip_total[l];
      rst_n = 1'b1; cap_on = 1'b1; enable = 1'b1;
      t3 = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (locked[3] && t3 < 0) t3 = i;
         if (&locked[3:1] && fail[0]) break;
      end
      check("lane3_lock_time", (t3 >= LC + 1 && t3 <= LC + SW + 3), 1);
      check("locked_1_3", locked[3:1], 3'b111);
      check("fail_0", fail[0], 1);
      check("locked_0", locked[0], 0);
      check("tx_fail_lane0", tx_data[0 +: DW], 0);
      check("slips_0", slip_total[0] - s0[0], 2*DW);
      check("slips_1", slip_total[1] - s0[1], 3);
      check("slips_2", slip_total[2] - s0[2], r2);
      check("slips_3", slip_total[3] - s0[3], 0);
      check("fail_1_3", fail[3:1], 0);
      check("slip_gap", gap_bad, 0);

      repeat (300) @(negedge clk);
      check("prbs_err_clean", err_count, 0);
      check("prbs_any_clean", error_any, 0);
      start = -1; errs = 0;
      for (int i = 0; i < cap.size(); i++) if (cap[i] != PAT) begin start = i; break; end
      if (start < 0) errs = 1000;
      else for (int k = 0; k < 32 && start + k < cap.size(); k++)
         if (cap[start + k] !== model_word(k)) errs++;
      check("prbs_tx_seq", errs, 0);
      cap_on = 1'b0;

      exp_any = 1'b0;
`ifdef SERDES_PRBS_ERR_INJECT_EN
      wpi = 0; prev_w = -1;
      for (int i = 0; i < 3; i++) if (pos[i] / DW != prev_w) begin wpi++; prev_w = pos[i] / DW; end
      for (int n = 0; n < 5; n++) begin
         @(negedge clk); inject[2] = 1'b1;
         @(negedge clk); inject[2] = 1'b0;
         repeat ($urandom_range(4, 12)) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("inject_err2", err_count[2*ECW +: ECW], 5 * wpi);
      check("inject_err1", err_count[1*ECW +: ECW], 0);
      check("inject_any", error_any, 1);
      exp_any = 1'b1;
`else
      wpi = pos[0];
`endif
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      check("clear_all", err_count, 0);
      check("clear_any_lag", error_any, exp_any);
      @(negedge clk);
      check("clear_any", error_any, 0);

      // Inverted lane: every word errored until saturation.
      mode[3] = 2; found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (err_count[3*ECW +: ECW] != 0) begin found = 1; break; end
      end
      check("inv_first_err", found, 1);
      check("any_lag_0", error_any, 0);
      @(negedge clk);
      check("any_lag_1", error_any, 1);
      repeat (1100) @(negedge clk);
      check("sat_err3", err_count[3*ECW +: ECW], {ECW{1'b1}});
      check("sat_locked3", locked[3], 1);
      check("sat_err1_2", err_count[1*ECW +: 2*ECW], 0);
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      check("clear_beats_err", err_count[3*ECW +: ECW], 0);
      repeat (5) @(negedge clk);
      check("count_after_clear", err_count[3*ECW +: ECW], 5);
      mode[3] = 0;

      @(negedge clk);
      held = int'(err_count[3*ECW +: ECW]);
      enable = 1'b0;
      @(negedge clk);
      check("dis_locked", locked, 0);
      check("dis_fail", fail, 0);
      check("dis_tx", tx_data, 0);
      check("dis_err_hold", err_count[3*ECW +: ECW], held);
      mode[0] = 0; rot_base[0] = slip_total[0];
      for (int l = 0; l < CH; l++) s0[l] = slip_total[l];
      enable = 1'b1;
      @(negedge clk);
      check("retrain_tx0", tx_data[0 +: DW], PAT);
      for (int i = 0; i < 100 && locked != 4'hF; i++) @(negedge clk);
      check("relock_all", locked, 4'hF);
      check("relock_slips0", slip_total[0] - s0[0], 0);

      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_tx", tx_data, 0);
      check("mid_rst_bitslip", bitslip, 0);
      check("mid_rst_locked", locked, 0);
      check("mid_rst_fail", fail, 0);
      check("mid_rst_err", err_count, 0);
      check("mid_rst_any", error_any, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 100 && locked != 4'hF; i++) @(negedge clk);
      check("post_rst_lock", locked, 4'hF);
      repeat (50) @(negedge clk);
      check("post_rst_err", err_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
